// File: rtl/axistream_upsizer_pkg.sv
// Shared sizing helpers for the AXI-Stream width up-converter.
// Lane index width is derived here so every user sizes it identically.
package axistream_upsizer_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      for (int i = 0; i < 32; i++) begin
         if ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic int lane_idx_width(input int ratio);
      return (clog2(ratio) < 32'sd1) ? 32'sd1 : clog2(ratio);
   endfunction

endpackage

// File: rtl/axistream_upsizer.sv
// Packs RATIO narrow beats into one wide word with per-lane keep bits.
// The accumulation registers double as the registered output stage.
module axistream_upsizer
   import axistream_upsizer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          src_tvalid,
   output logic                          src_tready,
   input  logic [DATA_WIDTH-1:0]         src_tdata,
   input  logic                          src_tlast,
   output logic                          dest_tvalid,
   input  logic                          dest_tready,
   output logic [DATA_WIDTH*RATIO-1:0]   dest_tdata,
   output logic [RATIO-1:0]              dest_tkeep,
   output logic                          dest_tlast
);

   localparam int IDX_W = lane_idx_width(RATIO);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   logic [IDX_W-1:0]            idx_q,   idx_d;
   logic                        valid_q, valid_d;
   logic [DATA_WIDTH*RATIO-1:0] data_q,  data_d;
   logic [RATIO-1:0]            keep_q,  keep_d;
   logic                        last_q,  last_d;
   logic                        beat_acc_s;

   // A pending word blocks new beats only while downstream is stalling it.
   assign src_tready = !rst && (!valid_q || dest_tready);
   assign beat_acc_s = src_tvalid && src_tready;

   assign dest_tvalid = valid_q;
   assign dest_tdata  = data_q;
   assign dest_tkeep  = keep_q;
   assign dest_tlast  = last_q;

   // Next-state: retire the consumed word first, then merge the incoming beat.
   always_comb begin
      idx_d   = idx_q;
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;

      if (valid_q && dest_tready) begin
         valid_d = 1'b0;
         data_d  = '0;
         keep_d  = '0;
         last_d  = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (beat_acc_s) begin
         data_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = src_tdata;
         keep_d[idx_q] = 1'b1;
         if ((idx_q == LAST_IDX) || src_tlast) begin
            valid_d = 1'b1;
            last_d  = src_tlast;
            idx_d   = '0;
         end else begin
            idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
         end
      end else begin
         idx_d = idx_q;
      end
   end

   // State and output registers; reset discards any partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: doc/axistream_upsizer.md
Name: axistream_upsizer

Overview:
Width up-converter sitting directly downstream of bram_axistream_fifo. Consumes the FIFO's narrow dest stream (DATA_WIDTH data + tlast) and packs RATIO consecutive beats into one wide output word with per-lane byte-enable style keep bits. A packet ending early (tlast before RATIO beats) flushes a partial word. Fully registered output; sustains one input beat per clock with no bubbles.

Parameters:
DATA_WIDTH, 8, width of one input beat (matches FIFO DATA_WIDTH)
RATIO, 4, input beats per output word; legal range 1..16

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
src_tvalid  input  1  input beat valid (from FIFO dest_tvalid)
src_tready  output  1  input beat accepted when src_tvalid && src_tready
src_tdata  input  DATA_WIDTH  input beat data
src_tlast  input  1  last beat of packet
dest_tvalid  output  1  wide word valid
dest_tready  input  1  downstream ready
dest_tdata  output  DATA_WIDTH*RATIO  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
dest_tkeep  output  RATIO  lane k holds valid data when bit k set
dest_tlast  output  1  word contains packet's final beat

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst, sampled only at rising edge of clk.
- Reset values: dest_tvalid=0, dest_tdata=0, dest_tkeep=0, dest_tlast=0, internal lane index=0. src_tready is 0 during a cycle where rst is high.
- Lane order: first accepted beat of a word -> lane 0 (LSBs), next -> lane 1, etc.
- Lane index width: max(1, clog2(RATIO)); counts 0..RATIO-1, wraps to 0 on word completion.
- src_tready = !rst && (!dest_tvalid || dest_tready). Combinational from dest_tvalid (a register) and dest_tready; never depends on src_tvalid.
- Accumulation registers are the output registers: while lane index>0 and word incomplete, dest_tvalid=0 and partial lanes are held in dest_tdata/dest_tkeep.
- On accepted beat: write src_tdata into lane[index], set tkeep bit[index]. If index==RATIO-1 or src_tlast: set dest_tvalid=1, dest_tlast=src_tlast, index<=0. Else index<=index+1.
- Latency: word visible (dest_tvalid=1) the cycle after the completing beat is accepted.
- Output handshake: when dest_tvalid && dest_tready, word is consumed. If a beat is accepted in the same cycle, it starts a fresh word: lane 0 loaded, all other lanes cleared to data 0 / keep 0, dest_tlast cleared (unless the beat itself completes the word, RATIO=1 or src_tlast).
- Consumed with no new beat: dest_tvalid<=0, dest_tdata<=0, dest_tkeep<=0, dest_tlast<=0.
- Backpressure: while dest_tvalid && !dest_tready, outputs are held stable (AXI-Stream rule), src_tready=0.
- Partial word: unused lanes have data 0 and keep 0; keep is always contiguous from bit 0.
- RATIO=1: registered pass-through, dest_tkeep=1 whenever valid.
- Reset mid-word: partial accumulation discarded, no word emitted.
- src_tdata/src_tlast ignored when src_tvalid=0.
- Throughput: RATIO input beats per output word with continuous src_tvalid and dest_tready=1, zero stall cycles.

Decomposition:
- Shared include: clog2 constant function (same one used for FIFO ADDR_WIDTH sizing) and a lane-slice helper macro.
- No sub-module; single always block for lane index plus output registers, one continuous assign for src_tready.
- Formal harness formal_axistream_upsizer in the same style as the FIFO harness: reset assumed in first cycle, stability of dest_* under backpressure, keep contiguity, lane index < RATIO.

Test Plan:
- Reset then 8 beats 0x01..0x08, tlast on 8th, dest_tready=1 -> words 0x04030201 keep 0xF last 0, then 0x08070605 keep 0xF last 1, each one cycle after 4th/8th beat.
- 3 beats 0xAA,0xBB,0xCC with tlast on 3rd -> word 0x00CCBBAA keep 0x7 last 1; next packet starts in lane 0.
- Single beat 0x5A with tlast -> word 0x0000005A keep 0x1 last 1.
- Full word pending, dest_tready=0 for 5 cycles -> src_tready=0, dest_tdata/tkeep/tlast stable; on dest_tready=1 a concurrent beat 0x11 is accepted into lane 0 of new word, keep 0x1.
- Continuous 16 beats, src_tvalid=1 and dest_tready=1 throughout -> exactly 4 words, no stall cycle on src_tready.
- rst asserted after 2 beats of a word -> no output word; next 4 beats 0x21..0x24 yield 0x24232221 keep 0xF.
